decision_demux: RTL and testbench
=================================

Name: decision_demux

Overview:
- Routes a stream of WIDTH-bit decision words to one of four registered output channels. It is the distribution-side counterpart of the 4:1 decision selector.
- Each channel holds its word with a valid flag until the downstream consumer acknowledges it.
- Two routing modes: explicit (Select picks the channel) and automatic (round-robin over free channels).
- Sits between the decision source and the four per-voice note drivers.

Parameters:
- WIDTH, 4, bit width of each decision word and each channel register.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Auto  in  1  0 = explicit routing via Select; 1 = round-robin routing.
- Select  in  2  target channel when Auto=0; ignored when Auto=1.
- InData  in  WIDTH  decision word to deliver.
- InValid  in  1  InData is valid this cycle.
- InReady  out  1  block accepts InData this cycle (combinational).
- O0, O1, O2, O3  out  WIDTH each  channel data registers.
- OutValid  out  4  bit i set while channel i holds an unacknowledged word.
- OutAck  in  4  bit i: consumer of channel i takes its word this cycle.
- RRPtr  out  2  round-robin start pointer.
- Overrun  out  1  one-cycle pulse when an unacknowledged word is overwritten.

Behaviour:
- Reset (async, any time, including mid-transfer): O0..O3=0, OutValid=4'b0000, RRPtr=0, Overrun=0. InReady follows its combinational rule from the reset state.
- Channel i is "free" this cycle when OutValid[i]=0 or OutAck[i]=1.
- Target selection, Auto=0: target = Select.
- Target selection, Auto=1: target = first free channel searching RRPtr, RRPtr+1, RRPtr+2, RRPtr+3 (mod 4). If no channel is free, there is no target.
- InReady = 1 when a target exists and that target is free; otherwise 0. InReady does not depend on InValid.
- Transfer = InValid & InReady. On the next edge: O[target] <= InData and OutValid[target] <= 1.
  - Auto=1: RRPtr <= target+1 (2-bit wrap, 3 -> 0).
  - Auto=0: RRPtr unchanged.
- Latency: word visible on O[target] with OutValid set 1 cycle after the transfer edge.
- OutAck[i] with OutValid[i]=1 and no write to i: OutValid[i] <= 0. O[i] retains its last value; it is not cleared.
- OutAck[i] with OutValid[i]=0: ignored.
- Simultaneous OutAck[i] and transfer to channel i: new word loaded, OutValid[i] stays 1, no Overrun.
- Acks on other channels are processed in the same cycle as a transfer, independently.
- Auto toggled mid-stream: no flush; RRPtr is retained and the new mode applies from that cycle.
- Select or InData changing while InValid=0: no effect.
- All four channels full, no acks: InReady=0 in both modes; state is held.

Optional Feature:
- Macro: DECISION_DEMUX_OVERWRITE_EN.
- Defined:
  - Auto=0: InReady is constantly 1.
  - Auto=1: if no channel is free, target = RRPtr and InReady=1.
  - A transfer into a channel with OutValid=1 and OutAck=0 overwrites it and pulses Overrun for exactly the cycle after the transfer edge.
  - RRPtr advances as normal in Auto=1.
- Not defined: Overrun is tied to 0 and the stalling rules above apply unchanged.

Test Plan:
- Reset asserted mid-operation with OutValid=4'b1011 -> all outputs zero immediately, without waiting for a clock edge; after release, RRPtr=0.
- Auto=0, Select=2, InData=4'hA, InValid=1 for one cycle -> next cycle O2=4'hA, OutValid=4'b0100, RRPtr=0; OutAck[2] pulse -> OutValid=0, O2 still 4'hA.
- Auto=0, channel 1 full, Select=1, InValid=1 -> InReady=0 with no change; assert OutAck[1] with InData=4'h5 the same cycle -> InReady=1, O1=4'h5, OutValid[1] stays 1.
- Auto=1, InValid held 1, data 1,2,3,4,5 with no acks -> O0..O3 = 1,2,3,4; RRPtr path 0->1->2->3->0; 5th cycle InReady=0. Then OutAck[2] -> word 5 lands in O2, RRPtr=3.
- Auto=1 with RRPtr=3 and channel 3 full, channel 0 free -> word goes to O0 (wrap), RRPtr=1.
- DECISION_DEMUX_OVERWRITE_EN, Auto=0, channel 0 full, Select=0, InData=4'hF -> O0=4'hF, Overrun high exactly one cycle; without the macro -> InReady=0, Overrun stays 0.

Source files
------------

// File: rtl/decision_demux.sv
// decision_demux: routes WIDTH-bit decision words to four acknowledged output channels.
// Define DECISION_DEMUX_OVERWRITE_EN to let writes overwrite unacknowledged words and pulse overrun_o.
module decision_demux #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             auto_i,
  input  logic [1:0]       select_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] o0_o,
  output logic [WIDTH-1:0] o1_o,
  output logic [WIDTH-1:0] o2_o,
  output logic [WIDTH-1:0] o3_o,
  output logic [3:0]       out_valid_o,
  input  logic [3:0]       out_ack_i,
  output logic [1:0]       rr_ptr_o,
  output logic             overrun_o
);
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [3:0] valid_q, valid_d, free;
  logic [1:0] rr_q, rr_d, auto_tgt, tgt, idx;
  logic auto_found, xfer;
  assign free = ~valid_q | out_ack_i;
  // Scan from the far end back so the candidate closest to rr_q wins.
  always_comb begin
    auto_found = 1'b0;
    auto_tgt   = rr_q;
    idx        = rr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_q + 2'(k);
      if (free[idx]) begin
        auto_found = 1'b1;
        auto_tgt   = idx;
      end
    end
  end
  assign tgt = auto_i ? auto_tgt : select_i;
`ifdef DECISION_DEMUX_OVERWRITE_EN
  logic overrun_q, overrun_d;
  assign in_ready_o = 1'b1;
  assign overrun_d  = xfer & valid_q[tgt] & ~out_ack_i[tgt];
  assign overrun_o  = overrun_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) overrun_q <= 1'b0;
    else       overrun_q <= overrun_d;
  end
`else
  assign in_ready_o = (auto_i ? auto_found : 1'b1) & free[tgt];
  assign overrun_o  = 1'b0;
`endif
  assign xfer = in_valid_i & in_ready_o;
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~out_ack_i;
    rr_d    = rr_q;
    if (xfer) begin
      data_d[tgt]  = in_data_i;
      valid_d[tgt] = 1'b1;
      rr_d         = auto_i ? tgt + 2'd1 : rr_q;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
      valid_q <= '0;
      rr_q    <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
    end
  end
  assign o0_o        = data_q[0];
  assign o1_o        = data_q[1];
  assign o2_o        = data_q[2];
  assign o3_o        = data_q[3];
  assign out_valid_o = valid_q;
  assign rr_ptr_o    = rr_q;
endmodule

// File: tb/tb_decision_demux.sv
// tb_decision_demux: directed and random checks of decision_demux against a queue-free channel model.
module tb_decision_demux;
  logic clk = 1'b0, rst = 1'b1, auto_s = 1'b0, in_valid = 1'b0, in_ready, overrun;
  logic [1:0] sel = '0, rr_ptr;
  logic [3:0] in_data = '0, o0, o1, o2, o3, out_valid, out_ack = '0;
  int cmp_cnt = 0, fail_cnt = 0;
  int m_data [4];
  bit m_valid [4];
  int m_rr;
  bit m_ovr;
  decision_demux #(.WIDTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .auto_i(auto_s), .select_i(sel), .in_data_i(in_data),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .o0_o(o0), .o1_o(o1), .o2_o(o2), .o3_o(o3),
    .out_valid_o(out_valid), .out_ack_i(out_ack), .rr_ptr_o(rr_ptr), .overrun_o(overrun)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_data[i] = 0;
      m_valid[i] = 0;
    end
    m_rr = 0;
    m_ovr = 0;
  endtask
  function automatic bit is_free(int c, logic [3:0] ack);
    return !m_valid[c] || ack[c];
  endfunction
  // Returns the model's ready flag and fills in its chosen channel.
  function automatic bit model_route(bit a, int s, logic [3:0] ack, output int t);
    bit found = 0;
    t = m_rr;
    if (a) begin
      for (int j = 0; j < 4; j++)
        if (!found && is_free((m_rr + j) % 4, ack)) begin
          found = 1;
          t = (m_rr + j) % 4;
        end
    end else begin
      t = s;
      found = is_free(s, ack);
    end
`ifdef DECISION_DEMUX_OVERWRITE_EN
    found = 1;
`endif
    return found;
  endfunction
  task automatic chk_state(input string tag);
    logic [3:0] mv;
    for (int i = 0; i < 4; i++) mv[i] = m_valid[i];
    chk({tag, ".o0"}, o0, m_data[0]);
    chk({tag, ".o1"}, o1, m_data[1]);
    chk({tag, ".o2"}, o2, m_data[2]);
    chk({tag, ".o3"}, o3, m_data[3]);
    chk({tag, ".valid"}, out_valid, mv);
    chk({tag, ".rr"}, rr_ptr, m_rr);
    chk({tag, ".overrun"}, overrun, m_ovr);
  endtask
  task automatic step(input string tag, input bit a, input int s, input int d, input bit v,
                      input logic [3:0] ack);
    int t;
    bit rdy, xfer;
    auto_s = a;
    sel = 2'(s);
    in_data = 4'(d);
    in_valid = v;
    out_ack = ack;
    @(negedge clk);
    rdy = model_route(a, s, ack, t);
    chk({tag, ".ready"}, in_ready, rdy);
    @(posedge clk);
    xfer = v && rdy;
    m_ovr = xfer && m_valid[t] && !ack[t];
`ifndef DECISION_DEMUX_OVERWRITE_EN
    m_ovr = 0;
`endif
    for (int i = 0; i < 4; i++) if (ack[i]) m_valid[i] = 0;
    if (xfer) begin
      m_data[t] = d & 15;
      m_valid[t] = 1;
      if (a) m_rr = (t + 1) % 4;
    end
    #1;
    chk_state(tag);
  endtask
  initial begin
    model_reset();
    #12;
    chk_state("reset");
    chk("reset.ready", in_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    step("exp_a", 0, 2, 'hA, 1, 4'b0000);
    step("ack2", 0, 0, 0, 0, 4'b0100);
    step("fill1", 0, 1, 3, 1, 4'b0000);
    step("stall1", 0, 1, 7, 1, 4'b0000);
    step("ackw1", 0, 1, 5, 1, 4'b0010);
    step("clear", 0, 0, 0, 0, 4'b1111);
    for (int k = 1; k <= 5; k++) step("rr_fill", 1, 0, k, 1, 4'b0000);
    step("rr_ack2", 1, 0, 5, 1, 4'b0100);
    step("rr_wrap", 1, 0, 6, 1, 4'b0001);
    step("ow_ch0", 0, 0, 'hF, 1, 4'b0000);
    step("ow_idle", 0, 0, 0, 0, 4'b0000);
    step("idle_sel", 0, 3, 9, 0, 4'b0000);
    for (int k = 0; k < 400; k++)
      step("rand", 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, 4'($urandom) & 4'($urandom));
    step("pre_rst", 0, 3, 'hC, 1, 4'b0000);
    in_valid = 1'b0;
    out_ack = '0;
    #3 rst = 1'b1;
    model_reset();
    #1;
    chk_state("async_rst");
    chk("async_rst.ready", in_ready, 1);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk_state("post_rst");
    step("post_rst_auto", 1, 0, 'hB, 1, 4'b0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end
endmodule
